// File: rtl/time_to_bcd_pkg.sv
// Shared constants and types for the seconds-to-MM:SS BCD converter.
package time_to_bcd_pkg;

    localparam int SECS_PER_MIN = 60;
    localparam int BCD_BASE     = 10;
    localparam int MAX_SECS     = 5999;

    localparam int DIGIT_W = 4;
    localparam int MIN_W   = 7;   // minutes, 0..99
    localparam int SVAL_W  = 6;   // seconds, 0..59

    typedef enum logic [1:0] {
        IDLE,
        DIV60,
        SPLIT,
        DONE
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } digits_t;

endpackage

// File: rtl/time_to_bcd_if.sv
// Start/busy/done request bus and MM:SS digit result of the converter.
interface time_to_bcd_if
    import time_to_bcd_pkg::*;
#(
    parameter int SEC_W = 13
);

    logic               start;
    logic [SEC_W-1:0]   secs_in;
    logic               busy;
    logic               done;
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic               overflow;

    modport master (
        output start, secs_in,
        input  busy, done, min_tens, min_ones, sec_tens, sec_ones, overflow
    );

    modport slave (
        input  start, secs_in,
        output busy, done, min_tens, min_ones, sec_tens, sec_ones, overflow
    );

endinterface

// File: rtl/time_to_bcd_split_step.sv
// One restoring-division step by ten: subtract 10 and bump the tens digit
// when the value is at least 10, otherwise pass both through unchanged.
module bcd_split_step
    import time_to_bcd_pkg::*;
#(
    parameter int W = MIN_W
) (
    input  logic [W-1:0]       val_i,
    input  logic [DIGIT_W-1:0] tens_i,
    output logic [W-1:0]       val_o,
    output logic [DIGIT_W-1:0] tens_o,
    output logic               ge_o
);

    // NOTE: every output gets a default before the if, so no latch is inferred.
    always_comb begin
        ge_o   = (val_i >= W'(BCD_BASE));
        val_o  = val_i;
        tens_o = tens_i;
        if (ge_o) begin
            val_o  = val_i - W'(BCD_BASE);
            tens_o = tens_i + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/time_to_bcd.sv
// Sequential binary-seconds to MM:SS BCD converter: repeated subtraction of
// 60 for minutes, then parallel subtraction of 10 for both digit pairs.
module time_to_bcd
    import time_to_bcd_pkg::*;
#(
    parameter int SEC_W = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    time_to_bcd_if.slave  bus
);

    localparam logic [SEC_W-1:0] MAX_IN  = SEC_W'(MAX_SECS);
    localparam logic [SEC_W-1:0] MIN_SEC = SEC_W'(SECS_PER_MIN);

    state_e              state_q, state_d;
    logic [SEC_W-1:0]    rem_q,   rem_d;
    logic [MIN_W-1:0]    min_r_q, min_r_d;
    logic                ovf_r_q, ovf_r_d;
    logic [MIN_W-1:0]    mval_q,  mval_d;
    logic [SVAL_W-1:0]   sval_q,  sval_d;
    logic [DIGIT_W-1:0]  mt_q,    mt_d;
    logic [DIGIT_W-1:0]  st_q,    st_d;
    digits_t             digits_q, digits_d;
    logic                overflow_q, overflow_d;

    logic [MIN_W-1:0]    mval_nxt;
    logic [SVAL_W-1:0]   sval_nxt;
    logic [DIGIT_W-1:0]  mt_nxt, st_nxt;
    logic                m_ge, s_ge;

    bcd_split_step #(.W(MIN_W)) u_min_step (
        .val_i  (mval_q),
        .tens_i (mt_q),
        .val_o  (mval_nxt),
        .tens_o (mt_nxt),
        .ge_o   (m_ge)
    );

    bcd_split_step #(.W(SVAL_W)) u_sec_step (
        .val_i  (sval_q),
        .tens_i (st_q),
        .val_o  (sval_nxt),
        .tens_o (st_nxt),
        .ge_o   (s_ge)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            min_r_q    <= '0;
            ovf_r_q    <= 1'b0;
            mval_q     <= '0;
            sval_q     <= '0;
            mt_q       <= '0;
            st_q       <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            min_r_q    <= min_r_d;
            ovf_r_q    <= ovf_r_d;
            mval_q     <= mval_d;
            sval_q     <= sval_d;
            mt_q       <= mt_d;
            st_q       <= st_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        min_r_d    = min_r_q;
        ovf_r_d    = ovf_r_q;
        mval_d     = mval_q;
        sval_d     = sval_q;
        mt_d       = mt_q;
        st_d       = st_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = (bus.secs_in > MAX_IN) ? MAX_IN : bus.secs_in;
                    min_r_d = '0;
                    ovf_r_d = (bus.secs_in > MAX_IN);
                    state_d = DIV60;
                end
            end

            DIV60: begin
                if (rem_q >= MIN_SEC) begin
                    rem_d   = rem_q - MIN_SEC;
                    min_r_d = min_r_q + MIN_W'(1);
                end else begin
                    mval_d  = min_r_q;
                    sval_d  = rem_q[SVAL_W-1:0];
                    mt_d    = '0;
                    st_d    = '0;
                    state_d = SPLIT;
                end
            end

            SPLIT: begin
                if (m_ge || s_ge) begin
                    mval_d = mval_nxt;
                    mt_d   = mt_nxt;
                    sval_d = sval_nxt;
                    st_d   = st_nxt;
                end else begin
                    // All four digits update on one edge so the display
                    // never shows a half-converted time.
                    digits_d.min_tens = mt_q;
                    digits_d.min_ones = mval_q[DIGIT_W-1:0];
                    digits_d.sec_tens = st_q;
                    digits_d.sec_ones = sval_q[DIGIT_W-1:0];
                    overflow_d        = ovf_r_q;
                    state_d           = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == DIV60) || (state_q == SPLIT);
    assign bus.done     = (state_q == DONE);
    assign bus.min_tens = digits_q.min_tens;
    assign bus.min_ones = digits_q.min_ones;
    assign bus.sec_tens = digits_q.sec_tens;
    assign bus.sec_ones = digits_q.sec_ones;
    assign bus.overflow = overflow_q;

endmodule
